// File: rtl/rs232_pkg.sv
// Shared types and defaults for the RS232 echo-path byte buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package rs232_pkg;

    localparam int RS232_BYTE_W          = 8;
    localparam int RS232_FIFO_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ISSUE_WAIT = 2'd1,
        TX_BUSY    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/rs232_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
// Latency: write visible after the edge; read is combinational from rd_addr.
// Backpressure: none; the caller guards wr_en.
module rs232_fifo_ram
    import rs232_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2,
    parameter int WIDTH      = RS232_BYTE_W
) (
    input  logic                  clock,
    input  logic                  wr_en,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_dat,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_dat
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/rs232_fifo.sv
// Byte FIFO between RS232 receiver and transmitter with a tx_rdy-paced issue sequencer.
// Latency: in_vld at edge N -> tx_vld high for the cycle after edge N+1 (empty FIFO, idle tx).
// Backpressure: tx_rdy paces issues; input overruns when full are dropped and flagged sticky.
module rs232_fifo
    import rs232_pkg::*;
#(
    parameter int DEPTH_LOG2 = RS232_FIFO_DEPTH_LOG2,
    parameter int WIDTH      = RS232_BYTE_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_vld,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  tx_rdy,
    output logic                  tx_vld,
    output logic [WIDTH-1:0]      tx_data,
    input  logic                  clr_ovf,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    seq_state_t              state;
    seq_state_t              state_nxt;
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     count_q;
    logic [WIDTH-1:0]        rd_dat;
    logic                    issue;
    logic                    wr_acc;
    logic                    drop;

    assign count = count_q;
    assign empty = (count_q == '0);
    assign full  = (count_q == DEPTH_CNT);

    // A read frees a slot on the same edge, so a full FIFO can still accept then.
    assign wr_acc = in_vld && (!full || issue);
    assign drop   = in_vld && full && !issue;

    rs232_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_ram (
        .clock   (clock),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_dat  (in_data),
        .rd_addr (rd_ptr),
        .rd_dat  (rd_dat)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       if (issue)   state_nxt = ISSUE_WAIT;
            ISSUE_WAIT: if (!tx_rdy) state_nxt = TX_BUSY;
            TX_BUSY:    if (tx_rdy)  state_nxt = IDLE;
            default:                 state_nxt = IDLE;
        endcase
    end

    always_comb begin
        issue = (state == IDLE) && !empty && tx_rdy;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count_q  <= '0;
            overflow <= 1'b0;
            tx_vld   <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_vld <= issue;
            if (issue) begin
                tx_data <= rd_dat;
                rd_ptr  <= rd_ptr + 1'b1;
            end
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case ({wr_acc, issue})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A drop on the same edge as a clear keeps the flag set.
            if (drop) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rs232_fifo.sv
// Self-checking bench for rs232_fifo: vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_rs232_fifo;

    localparam int DL    = 4;
    localparam int W     = 8;
    localparam int DEPTH = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_vld;
    logic [W-1:0]  in_data;
    logic          tx_rdy;
    logic          tx_vld;
    logic [W-1:0]  tx_data;
    logic          clr_ovf;
    logic [DL:0]   count;
    logic          empty;
    logic          full;
    logic          overflow;

    always #5 clock = ~clock;

    rs232_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .in_vld   (in_vld),
        .in_data  (in_data),
        .tx_rdy   (tx_rdy),
        .tx_vld   (tx_vld),
        .tx_data  (tx_data),
        .clr_ovf  (clr_ovf),
        .count    (count),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    // Reference model: byte queue plus the issue/handshake rules.
    logic [7:0] mq[$];
    bit         m_ovf;
    bit         m_vld;
    logic [7:0] m_data;
    int         m_phase;   // 0 ready to issue, 1 waiting for tx to take, 2 tx shifting

    function automatic void model_reset();
        mq.delete();
        m_ovf   = 0;
        m_vld   = 0;
        m_data  = 8'h00;
        m_phase = 0;
    endfunction

    function automatic void model_step(bit vld, logic [7:0] d, bit rdy, bit clr);
        bit is_full;
        bit rd;
        bit wr;
        bit drp;
        is_full = (mq.size() == DEPTH);
        rd      = (m_phase == 0) && (mq.size() != 0) && rdy;
        wr      = vld && (!is_full || rd);
        drp     = vld && is_full && !rd;
        m_vld   = rd;
        if (rd) m_data = mq.pop_front();
        if (wr) mq.push_back(d);
        if (drp) m_ovf = 1;
        else if (clr) m_ovf = 0;
        case (m_phase)
            0: if (rd)   m_phase = 1;
            1: if (!rdy) m_phase = 2;
            2: if (rdy)  m_phase = 0;
            default: m_phase = 0;
        endcase
    endfunction

    function automatic void check_model(string tag);
        chk({tag, ".tx_vld"},   32'(tx_vld),   32'(m_vld));
        chk({tag, ".tx_data"},  32'(tx_data),  32'(m_data));
        chk({tag, ".count"},    32'(count),    32'(mq.size()));
        chk({tag, ".empty"},    32'(empty),    32'(mq.size() == 0));
        chk({tag, ".full"},     32'(full),     32'(mq.size() == DEPTH));
        chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    endfunction

    // Transmitter model and pulse capture.
    bit         auto_xmtr;
    int         busy_len;
    int         busy_cnt;
    int         pulses;
    logic [7:0] obs[$];

    task automatic tick(bit vld, logic [7:0] d, bit clr);
        if (auto_xmtr) tx_rdy = (busy_cnt == 0);
        in_vld  = vld;
        in_data = d;
        clr_ovf = clr;
        model_step(vld, d, tx_rdy, clr);
        @(posedge clock);
        @(negedge clock);
        check_model("cyc");
        if (tx_vld === 1'b1) begin
            pulses++;
            obs.push_back(tx_data);
            busy_cnt = busy_len;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        in_vld    = 1'b0;
        in_data   = '0;
        clr_ovf   = 1'b0;
        tx_rdy    = 1'b1;
        auto_xmtr = 0;
        busy_cnt  = 0;
        busy_len  = 3;
        pulses    = 0;
        obs.delete();
        model_reset();
        repeat (2) @(negedge clock);
        check_model("rst");
        reset = 1'b1;
    endtask

    typedef struct {
        bit         vld;
        logic [7:0] d;
        bit         rdy;
        bit         clr;
        bit         e_vld;
        logic [7:0] e_data;
        int         e_cnt;
        bit         e_empty;
        bit         e_full;
        bit         e_ovf;
    } vec_t;

    vec_t tbl[4];

    initial begin
        tbl[0] = '{vld:0, d:8'h00, rdy:1, clr:0, e_vld:0, e_data:8'h00, e_cnt:0, e_empty:1, e_full:0, e_ovf:0};
        tbl[1] = '{vld:1, d:8'h41, rdy:1, clr:0, e_vld:0, e_data:8'h00, e_cnt:1, e_empty:0, e_full:0, e_ovf:0};
        tbl[2] = '{vld:0, d:8'h00, rdy:1, clr:0, e_vld:1, e_data:8'h41, e_cnt:0, e_empty:1, e_full:0, e_ovf:0};
        tbl[3] = '{vld:0, d:8'h00, rdy:0, clr:0, e_vld:0, e_data:8'h41, e_cnt:0, e_empty:1, e_full:0, e_ovf:0};

        // Reset and single byte
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tx_rdy = tbl[i].rdy;
            tick(tbl[i].vld, tbl[i].d, tbl[i].clr);
            chk($sformatf("vec%0d.tx_vld", i),   32'(tx_vld),   32'(tbl[i].e_vld));
            chk($sformatf("vec%0d.tx_data", i),  32'(tx_data),  32'(tbl[i].e_data));
            chk($sformatf("vec%0d.count", i),    32'(count),    32'(tbl[i].e_cnt));
            chk($sformatf("vec%0d.empty", i),    32'(empty),    32'(tbl[i].e_empty));
            chk($sformatf("vec%0d.full", i),     32'(full),     32'(tbl[i].e_full));
            chk($sformatf("vec%0d.overflow", i), 32'(overflow), 32'(tbl[i].e_ovf));
        end
        tx_rdy = 1'b0;
        repeat (20) tick(0, 8'h00, 0);
        tx_rdy = 1'b1;
        repeat (5) tick(0, 8'h00, 0);
        chk("single.pulses", 32'(pulses), 32'd1);
        chk("single.count", 32'(count), 32'd0);

        // Burst while busy
        do_reset();
        tx_rdy = 1'b0;
        for (int i = 1; i <= 5; i++) tick(1, 8'(i), 0);
        chk("burst.count", 32'(count), 32'd5);
        auto_xmtr = 1;
        repeat (40) tick(0, 8'h00, 0);
        chk("burst.pulses", 32'(pulses), 32'd5);
        for (int i = 0; i < 5 && i < obs.size(); i++)
            chk($sformatf("burst.byte%0d", i), 32'(obs[i]), 32'(i + 1));

        // Full and overflow
        do_reset();
        tx_rdy = 1'b0;
        for (int i = 0; i < 17; i++) tick(1, 8'(8'h10 + i), 0);
        chk("ovf.full", 32'(full), 32'd1);
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.flag", 32'(overflow), 32'd1);
        auto_xmtr = 1;
        repeat (150) tick(0, 8'h00, 0);
        chk("ovf.pulses", 32'(pulses), 32'd16);
        for (int i = 0; i < 16 && i < obs.size(); i++)
            chk($sformatf("ovf.byte%0d", i), 32'(obs[i]), 32'(8'h10 + i));
        chk("ovf.sticky", 32'(overflow), 32'd1);
        tick(0, 8'h00, 1);
        chk("ovf.cleared", 32'(overflow), 32'd0);

        // Simultaneous read and write at full
        do_reset();
        tx_rdy = 1'b0;
        for (int i = 0; i < 16; i++) tick(1, 8'(8'h30 + i), 0);
        tx_rdy = 1'b1;
        tick(1, 8'hAA, 0);
        chk("rw.count", 32'(count), 32'd16);
        chk("rw.overflow", 32'(overflow), 32'd0);
        chk("rw.tx_data", 32'(tx_data), 32'h30);
        auto_xmtr = 1;
        repeat (150) tick(0, 8'h00, 0);
        chk("rw.pulses", 32'(pulses), 32'd17);
        if (obs.size() == 17) chk("rw.last", 32'(obs[16]), 32'hAA);
        else chk("rw.obs_size", 32'(obs.size()), 32'd17);

        // Wrap-around streaming
        do_reset();
        auto_xmtr = 1;
        busy_len  = 2;
        for (int i = 0; i < 40; i++) begin
            tick(1, 8'(i), 0);
            repeat (4) tick(0, 8'h00, 0);
        end
        repeat (40) tick(0, 8'h00, 0);
        chk("wrap.pulses", 32'(pulses), 32'd40);
        chk("wrap.overflow", 32'(overflow), 32'd0);
        for (int i = 0; i < 40 && i < obs.size(); i++)
            chk($sformatf("wrap.byte%0d", i), 32'(obs[i]), 32'(i));

        // Reset mid-operation during ISSUE_WAIT with three bytes left
        do_reset();
        tx_rdy = 1'b0;
        for (int i = 0; i < 4; i++) tick(1, 8'(8'h50 + i), 0);
        tx_rdy = 1'b1;
        tick(0, 8'h00, 0);
        chk("mid.tx_vld_pre", 32'(tx_vld), 32'd1);
        chk("mid.count_pre", 32'(count), 32'd3);
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("mid.tx_vld", 32'(tx_vld), 32'd0);
        chk("mid.count", 32'(count), 32'd0);
        chk("mid.empty", 32'(empty), 32'd1);
        @(negedge clock);
        reset     = 1'b1;
        busy_cnt  = 0;
        pulses    = 0;
        auto_xmtr = 1;
        repeat (20) tick(0, 8'h00, 0);
        chk("mid.pulses", 32'(pulses), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tx_rdy = ($urandom_range(99) < ((c < 1500) ? 25 : 80));
            tick($urandom_range(99) < 45, 8'($urandom), $urandom_range(99) < 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
